// File: rtl/mips_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_data_mem_arbiter
//
// Purpose
//   Shares the single data-memory port between two requesters:
//     port 0 = CPU data port (from mips_cpu_harvard data_* signals)
//     port 1 = DMA / loader port (bench preload, future peripherals)
//   The memory has a fixed one-cycle read latency. Writes complete in the
//   cycle they are granted; reads stall the requester for exactly one cycle.
//   Ties are resolved either round-robin or with CPU priority plus a
//   starvation guard that forces the DMA through after MAX_STALL lost ties.
//
// Parameters
//   CPU_PRIORITY  1: CPU wins ties unless the DMA has lost MAX_STALL ties in
//                 a row; 0: pure round-robin.
//   MAX_STALL     number of consecutive ties the DMA may lose (1..255).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clk_enable        0 freezes all state, blocks memory access, stalls both
//   cpu_*             port 0: address, read, write, writedata in;
//                     readdata, waitrequest out
//   dma_*             port 1: same signal set as port 0
//   mem_*             to/from the data memory (address, read, write,
//                     writedata out; readdata in, valid the cycle after
//                     mem_read)
//   grant_owner       debug: port holding the memory this cycle (0=CPU,1=DMA)
//
// Handshake (both requester ports)
//   A requester raises read or write together with address/writedata and
//   holds all of them stable while waitrequest=1. The transfer completes in
//   the cycle where (read|write)=1 and waitrequest=0; for a read, readdata
//   is valid in exactly that cycle. A port that is not requesting sees
//   waitrequest=0 while the arbiter is idle. Read has precedence over write
//   when both are raised on one port.
// -----------------------------------------------------------------------------
module mips_data_mem_arbiter #(
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_STALL    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,

    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,

    input  logic [31:0] dma_address,
    input  logic        dma_read,
    input  logic        dma_write,
    input  logic [31:0] dma_writedata,
    output logic [31:0] dma_readdata,
    output logic        dma_waitrequest,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,

    output logic        grant_owner
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    state_t     state;
    logic       owner;       // port whose read is in flight / last granted
    logic       last_grant;  // round-robin pointer
    logic [7:0] stall_cnt;   // consecutive ties lost by the DMA

    // Byte-lane bits are dropped: the memory is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_address[1:0], dma_address[1:0]};

    // -------------------------------------------------------------------------
    // Request decode and arbitration
    // -------------------------------------------------------------------------
    logic        cpu_req;
    logic        dma_req;
    logic        any_req;
    logic        tie;
    logic        winner;
    logic        win_read;
    logic [31:0] win_address;
    logic [31:0] win_writedata;

    assign cpu_req = cpu_read | cpu_write;
    assign dma_req = dma_read | dma_write;
    assign any_req = cpu_req | dma_req;
    assign tie     = cpu_req & dma_req;

    always_comb begin
        winner = 1'b0;
        if (cpu_req && !dma_req) begin
            winner = 1'b0;
        end else if (dma_req && !cpu_req) begin
            winner = 1'b1;
        end else if (CPU_PRIORITY != 0) begin
            // CPU keeps the port until the DMA has been starved long enough.
            winner = (stall_cnt >= STALL_LIMIT);
        end else begin
            winner = ~last_grant;
        end
    end

    // A read flag on the winning port turns the access into a read even if
    // write is also raised.
    assign win_read      = winner ? dma_read      : cpu_read;
    assign win_address   = winner ? dma_address   : cpu_address;
    assign win_writedata = winner ? dma_writedata : cpu_writedata;

    // -------------------------------------------------------------------------
    // State: FSM, owner, round-robin pointer, starvation counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;   // first round-robin tie goes to the CPU
            stall_cnt  <= 8'd0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        if (winner) begin
                            stall_cnt <= 8'd0;
                        end else if (tie && (stall_cnt < STALL_LIMIT)) begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                        if (win_read) begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Data is on mem_readdata this cycle; no read pipelining.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The granted port drives the memory combinationally in IDLE so
    // writes complete with zero stall.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_address     = 32'h0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = 32'h0;
        cpu_waitrequest = 1'b1;
        dma_waitrequest = 1'b1;
        cpu_readdata    = 32'h0;
        dma_readdata    = 32'h0;
        grant_owner     = owner;

        if (reset) begin
            grant_owner = 1'b0;
        end else if (clk_enable) begin
            if (state == IDLE) begin
                // Requesters stall until served; idle ports see no stall.
                cpu_waitrequest = cpu_req;
                dma_waitrequest = dma_req;
                if (any_req) begin
                    grant_owner   = winner;
                    mem_address   = {win_address[31:2], 2'b00};
                    mem_writedata = win_writedata;
                    if (win_read) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        if (winner) begin
                            dma_waitrequest = 1'b0;
                        end else begin
                            cpu_waitrequest = 1'b0;
                        end
                    end
                end
            end else begin
                // Read completion: only the owner is released.
                if (owner) begin
                    dma_waitrequest = 1'b0;
                    dma_readdata    = mem_readdata;
                end else begin
                    cpu_waitrequest = 1'b0;
                    cpu_readdata    = mem_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_data_mem_arbiter
//
// Two arbiter instances run side by side: u_rr (round-robin) and u_pri (CPU
// priority, MAX_STALL=3). Each has its own word memory behind it and its own
// transaction-level reference model (grant rules, starvation counter as a
// plain integer, shadow memory and a queue of expected read data).
// -----------------------------------------------------------------------------
module tb_mips_data_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    // ---------------- DUT signals, index 0 = u_rr, 1 = u_pri ----------------
    logic [31:0] c_addr [2];
    logic        c_rd   [2];
    logic        c_wr   [2];
    logic [31:0] c_wd   [2];
    logic [31:0] c_rdata[2];
    logic        c_wait [2];
    logic [31:0] d_addr [2];
    logic        d_rd   [2];
    logic        d_wr   [2];
    logic [31:0] d_wd   [2];
    logic [31:0] d_rdata[2];
    logic        d_wait [2];
    logic [31:0] m_addr [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2];
    logic        go     [2];

    mips_data_mem_arbiter #(.CPU_PRIORITY(0), .MAX_STALL(8)) u_rr (
        .clk(clk), .reset(rst), .clk_enable(en),
        .cpu_address(c_addr[0]), .cpu_read(c_rd[0]), .cpu_write(c_wr[0]),
        .cpu_writedata(c_wd[0]), .cpu_readdata(c_rdata[0]), .cpu_waitrequest(c_wait[0]),
        .dma_address(d_addr[0]), .dma_read(d_rd[0]), .dma_write(d_wr[0]),
        .dma_writedata(d_wd[0]), .dma_readdata(d_rdata[0]), .dma_waitrequest(d_wait[0]),
        .mem_address(m_addr[0]), .mem_read(m_rd[0]), .mem_write(m_wr[0]),
        .mem_writedata(m_wdata[0]), .mem_readdata(m_rdata[0]),
        .grant_owner(go[0])
    );

    mips_data_mem_arbiter #(.CPU_PRIORITY(1), .MAX_STALL(3)) u_pri (
        .clk(clk), .reset(rst), .clk_enable(en),
        .cpu_address(c_addr[1]), .cpu_read(c_rd[1]), .cpu_write(c_wr[1]),
        .cpu_writedata(c_wd[1]), .cpu_readdata(c_rdata[1]), .cpu_waitrequest(c_wait[1]),
        .dma_address(d_addr[1]), .dma_read(d_rd[1]), .dma_write(d_wr[1]),
        .dma_writedata(d_wd[1]), .dma_readdata(d_rdata[1]), .dma_waitrequest(d_wait[1]),
        .mem_address(m_addr[1]), .mem_read(m_rd[1]), .mem_write(m_wr[1]),
        .mem_writedata(m_wdata[1]), .mem_readdata(m_rdata[1]),
        .grant_owner(go[1])
    );

    // ---------------- data memories (gated by clk_enable) ----------------
    logic [31:0] bmem [2][16];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en) begin
                if (m_wr[i]) bmem[i][m_addr[i][5:2]] <= m_wdata[i];
                if (m_rd[i]) m_rdata[i] <= bmem[i][m_addr[i][5:2]];
            end
        end
    end

    // ---------------- reference model ----------------
    int          prio   [2] = '{0, 1};
    int          mstall [2] = '{8, 3};
    bit          m_pend [2];
    bit          m_pport[2];
    bit          m_last [2];
    bit          m_own  [2];
    int          m_loss [2];
    logic [31:0] ref_mem[2][16];
    logic [31:0] exp_q  [2][$];

    // samples of the last checked cycle, for directed checks and requesters
    logic        s_cw [2];
    logic        s_dw [2];
    logic        s_mr [2];
    logic        s_mw [2];
    logic        s_go [2];
    logic [31:0] s_crd[2];
    logic [31:0] s_drd[2];

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] pre [16];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's outputs from the rules, compare, then advance.
    task automatic model_cycle(input int i);
        bit          cq, dq, tie, w, rd_op;
        logic [31:0] a, wd, dummy;
        logic [31:0] e_ma, e_md, e_crd, e_drd;
        bit          e_mr, e_mw, e_cw, e_dw, e_go;

        cq    = c_rd[i] | c_wr[i];
        dq    = d_rd[i] | d_wr[i];
        tie   = cq && dq;
        if (tie) w = (prio[i] != 0) ? (m_loss[i] >= mstall[i]) : !m_last[i];
        else     w = dq;
        rd_op = w ? d_rd[i]   : c_rd[i];
        a     = w ? d_addr[i] : c_addr[i];
        wd    = w ? d_wd[i]   : c_wd[i];

        e_ma = 0; e_md = 0; e_crd = 0; e_drd = 0;
        e_mr = 0; e_mw = 0; e_cw = 1; e_dw = 1;
        e_go = m_own[i];
        if (rst) begin
            e_go = 0;
        end else if (en) begin
            if (m_pend[i]) begin
                e_go = m_pport[i];
                if (m_pport[i]) begin
                    e_dw = 0;
                    if (exp_q[i].size() > 0) e_drd = exp_q[i][0];
                end else begin
                    e_cw = 0;
                    if (exp_q[i].size() > 0) e_crd = exp_q[i][0];
                end
            end else begin
                e_cw = cq;
                e_dw = dq;
                if (cq || dq) begin
                    e_go = w;
                    e_ma = {a[31:2], 2'b00};
                    e_md = wd;
                    if (rd_op) begin
                        e_mr = 1;
                    end else begin
                        e_mw = 1;
                        if (w) e_dw = 0; else e_cw = 0;
                    end
                end
            end
        end

        s_cw[i] = c_wait[i];  s_dw[i] = d_wait[i];
        s_mr[i] = m_rd[i];    s_mw[i] = m_wr[i];
        s_go[i] = go[i];      s_crd[i] = c_rdata[i];  s_drd[i] = d_rdata[i];

        check_val($sformatf("u%0d mem_read", i),        32'(m_rd[i]),   32'(e_mr));
        check_val($sformatf("u%0d mem_write", i),       32'(m_wr[i]),   32'(e_mw));
        check_val($sformatf("u%0d mem_address", i),     m_addr[i],      e_ma);
        check_val($sformatf("u%0d mem_writedata", i),   m_wdata[i],     e_md);
        check_val($sformatf("u%0d cpu_waitrequest", i), 32'(c_wait[i]), 32'(e_cw));
        check_val($sformatf("u%0d dma_waitrequest", i), 32'(d_wait[i]), 32'(e_dw));
        check_val($sformatf("u%0d cpu_readdata", i),    c_rdata[i],     e_crd);
        check_val($sformatf("u%0d dma_readdata", i),    d_rdata[i],     e_drd);
        check_val($sformatf("u%0d grant_owner", i),     32'(go[i]),     32'(e_go));

        if (rst) begin
            m_pend[i] = 0; m_last[i] = 1; m_loss[i] = 0; m_own[i] = 0;
            exp_q[i].delete();
        end else if (en) begin
            if (m_pend[i]) begin
                m_pend[i] = 0;
                if (exp_q[i].size() > 0) dummy = exp_q[i].pop_front();
            end else if (cq || dq) begin
                m_last[i] = w;
                m_own[i]  = w;
                if (w) m_loss[i] = 0;
                else if (tie && m_loss[i] < mstall[i]) m_loss[i]++;
                if (rd_op) begin
                    m_pend[i]  = 1;
                    m_pport[i] = w;
                    exp_q[i].push_back(ref_mem[i][a[5:2]]);
                end else begin
                    ref_mem[i][a[5:2]] = wd;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) model_cycle(i);
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < 2; i++) begin
            c_rd[i] = rd; c_wr[i] = wr; c_addr[i] = addr; c_wd[i] = wd;
        end
    endtask

    task automatic set_dma(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < 2; i++) begin
            d_rd[i] = rd; d_wr[i] = wr; d_addr[i] = addr; d_wd[i] = wd;
        end
    endtask

    task automatic idle_all();
        set_cpu(0, 0, 32'h0, 32'h0);
        set_dma(0, 0, 32'h0, 32'h0);
    endtask

    task automatic rand_req(output logic rd, output logic wr, output logic [31:0] addr, output logic [31:0] wd);
        int r;
        r    = $urandom_range(0, 9);
        rd   = (r >= 4 && r <= 6) || (r == 9);
        wr   = (r >= 7);
        addr = 32'($urandom_range(0, 63));
        wd   = $urandom;
    endtask

    // Requesters keep a pending request stable until waitrequest drops.
    task automatic rand_inputs();
        for (int i = 0; i < 2; i++) begin
            if (!((c_rd[i] | c_wr[i]) && s_cw[i])) rand_req(c_rd[i], c_wr[i], c_addr[i], c_wd[i]);
            if (!((d_rd[i] | d_wr[i]) && s_dw[i])) rand_req(d_rd[i], d_wr[i], d_addr[i], d_wd[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; en = 1;
        idle_all();
        @(negedge clk);

        // reset with a live CPU request
        set_cpu(1, 0, 32'h4, 32'h0);
        tick();
        check_val("rst cpu_wait", 32'(s_cw[0]), 32'h1);
        check_val("rst dma_wait", 32'(s_dw[1]), 32'h1);
        check_val("rst mem_read", 32'(s_mr[0]), 32'h0);
        check_val("rst grant",    32'(s_go[1]), 32'h0);
        tick();
        rst = 0;
        idle_all();

        // preload all 16 words through the DMA port
        for (int k = 0; k < 16; k++) begin
            pre[k] = (k == 1) ? 32'h01FF5555 : $urandom;
            set_dma(0, 1, 32'(k * 4), pre[k]);
            tick();
            if (k == 0) begin
                check_val("preload dma_wait", 32'(s_dw[0]), 32'h0);
                check_val("preload mem_write", 32'(s_mw[1]), 32'h1);
            end
        end
        idle_all();
        tick();

        // 1: CPU read alone
        set_cpu(1, 0, 32'h4, 32'h0);
        tick();
        check_val("t1 mem_read", 32'(s_mr[0]), 32'h1);
        check_val("t1 wait first", 32'(s_cw[0]), 32'h1);
        tick();
        check_val("t1 wait second", 32'(s_cw[0]), 32'h0);
        check_val("t1 readdata", s_crd[0], 32'h01FF5555);
        idle_all();
        tick();

        // 2: CPU write alone, then read back
        set_cpu(0, 1, 32'h8, 32'hDEADBEEF);
        tick();
        check_val("t2 mem_write", 32'(s_mw[0]), 32'h1);
        check_val("t2 cpu_wait", 32'(s_cw[0]), 32'h0);
        set_cpu(1, 0, 32'h8, 32'h0);
        tick();
        tick();
        check_val("t2 readback", s_crd[1], 32'hDEADBEEF);
        idle_all();
        tick();

        // 3: continuous writes on both ports after reset
        rst = 1;
        tick();
        rst = 0;
        set_cpu(0, 1, 32'h20, 32'h11112222);
        set_dma(0, 1, 32'h24, 32'h33334444);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("t3 rr grant %0d", k), 32'(s_go[0]), 32'(k % 2));
        end

        // 4: continuous reads on both ports after reset
        rst = 1;
        tick();
        rst = 0;
        set_cpu(1, 0, 32'h30, 32'h0);
        set_dma(1, 0, 32'h34, 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k % 2 == 0) begin
                check_val($sformatf("t4 pri grant %0d", k), 32'(s_go[1]), 32'(k == 6));
                check_val($sformatf("t4 mem_read %0d", k), 32'(s_mr[1]), 32'h1);
            end
        end
        idle_all();
        tick();

        // 5: reset while a read is in flight
        set_cpu(1, 0, 32'h10, 32'h0);
        tick();
        rst = 1;
        tick();
        check_val("t5 rst cpu_wait", 32'(s_cw[0]), 32'h1);
        check_val("t5 rst dma_wait", 32'(s_dw[0]), 32'h1);
        check_val("t5 rst readdata", s_crd[0], 32'h0);
        rst = 0;
        idle_all();
        tick();
        check_val("t5 after cpu_wait", 32'(s_cw[0]), 32'h0);
        check_val("t5 after readdata", s_crd[0], 32'h0);

        // 6: clock-enable freeze during a DMA read
        set_dma(1, 0, 32'hC, 32'h0);
        tick();
        check_val("t6 mem_read", 32'(s_mr[0]), 32'h1);
        en = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t6 frozen mem_read", 32'(s_mr[0]), 32'h0);
            check_val("t6 frozen dma_wait", 32'(s_dw[0]), 32'h1);
            check_val("t6 frozen cpu_wait", 32'(s_cw[1]), 32'h1);
        end
        en = 1;
        tick();
        check_val("t6 dma_wait", 32'(s_dw[0]), 32'h0);
        check_val("t6 readdata", s_drd[0], pre[3]);
        check_val("t6 readdata pri", s_drd[1], pre[3]);
        idle_all();
        tick();

        // randomized traffic, occasional freeze and reset
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            rand_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
